// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipes : shared types and constants for the pipeline control unit.
//
// Contents:
//   STG_* localparams  - bit index of each inter-stage register in the
//                        4-bit en/flush vectors (0 = IF/ID ... 3 = MEM/WB).
//   pctrl_state_t      - redirect FSM state (IDLE, REDIR_PEND).
//   stage_ctrl_t       - bundled en/flush vectors for the four registers.
// ----------------------------------------------------------------------------
package pipes;

    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

    typedef enum logic {
        IDLE       = 1'b0,
        REDIR_PEND = 1'b1
    } pctrl_state_t;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect : combinational load-use comparator.
//
// Raises lu when the instruction in EX is a load whose destination (other than
// x0) is read by the instruction currently in ID.
//
// Ports:
//   id_rs1, id_rs2         in  REG_W : ID source registers
//   id_use_rs1, id_use_rs2 in  1     : the corresponding source is really read
//   ex_is_load             in  1     : EX instruction is a load
//   ex_rd                  in  REG_W : EX destination register
//   lu                     out 1     : load-use hazard
// ----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu
);

    logic rs1Hit;
    logic rs2Hit;

    // x0 is hard-wired, so a load targeting it can never create a hazard.
    assign rs1Hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2Hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu     = ex_is_load && (ex_rd != '0) && (rs1Hit || rs2Hit);

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl : pipeline control unit.
//
// Drives en/flush of the four inter-stage registers plus PC enable/redirect.
// Priority (highest first): data-memory stall, EX redirect, pending redirect
// behind an outstanding fetch, load-use hazard, instruction-fetch stall.
// All control outputs are combinational from inputs and state.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the stall_cycles and
// flush_count performance counters (and the CNT_W parameter).
//
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   i_busy, d_busy             : fetch / data access outstanding
//   id_rs1/2, id_use_rs1/2     : ID source operands
//   ex_is_load, ex_rd          : EX load info for load-use detection
//   ex_redirect, ex_target     : EX branch/jump redirect request
//   stage_en, stage_flush [4]  : per-register en / flush_en (0 = IF/ID)
//   pc_en, pc_redirect         : PC update enable / select redirect target
//   pc_target                  : redirect target
//   stall_cycles, flush_count  : perf counters (PIPE_CTRL_PERF_EN only)
// ----------------------------------------------------------------------------
module pipe_ctrl
    import pipes::*;
#(
    parameter int ADDR_W = 64,
    parameter int REG_W  = 5
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_busy,
    input  logic              d_busy,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    output logic [3:0]        stage_en,
    output logic [3:0]        stage_flush,
    output logic              pc_en,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] pc_target
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    pctrl_state_t      state_q, state_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    stage_ctrl_t       ctrl;
    logic              lu;
    logic              redirAccept;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .lu         (lu)
    );

    // A redirect is taken only from IDLE and never during a data stall
    // (EX is frozen then, so the same request shows up again later).
    assign redirAccept = (state_q == IDLE) && ex_redirect && !d_busy;

    // Priority mux: picks the control vector, PC controls and next state.
    // Reset forces the safe values combinationally so the effect is
    // immediate rather than waiting for an edge.
    always_comb begin
        ctrl.en     = 4'b1111;
        ctrl.flush  = 4'b0000;
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = tgt_q;
        state_d     = state_q;
        tgt_d       = tgt_q;

        if (reset) begin
            ctrl.flush = 4'b1111;
            pc_target  = '0;
            state_d    = IDLE;
        end else if (d_busy) begin
            ctrl.en = 4'b0000;
        end else if (redirAccept) begin
            ctrl.flush[STG_IFID] = 1'b1;
            ctrl.flush[STG_IDEX] = 1'b1;
            pc_redirect          = 1'b1;
            pc_target            = ex_target;
            if (i_busy) begin
                // Cannot steer the PC until the in-flight fetch returns.
                tgt_d   = ex_target;
                state_d = REDIR_PEND;
            end else begin
                pc_en = 1'b1;
            end
        end else if (state_q == REDIR_PEND) begin
            // Keep squashing whatever the stale fetch delivers into ID.
            ctrl.flush[STG_IFID] = 1'b1;
            pc_redirect          = 1'b1;
            pc_en                = !i_busy;
            if (!i_busy) begin
                state_d = IDLE;
            end
        end else if (lu) begin
            // IF/ID holds (not flushed) so the fetched instruction survives.
            ctrl.en[STG_IFID]    = 1'b0;
            ctrl.flush[STG_IDEX] = 1'b1;
        end else if (i_busy) begin
            ctrl.flush[STG_IFID] = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    assign stage_en    = ctrl.en;
    assign stage_flush = ctrl.flush;

    // Redirect FSM state and the held redirect target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Performance counters: cycles with the PC held, and accepted redirects.
    // Both wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (redirAccept) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl : self-checking bench for pipe_ctrl.
// Directed scenarios followed by randomized traffic; a reference model queues
// the expected response per cycle and a negedge monitor compares it.
// Define PIPE_CTRL_PERF_EN to also check the performance counters.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int ADDR_W = 64;
    localparam int REG_W  = 5;

    typedef struct {
        logic             rst;
        logic             pulse;
        logic             iBusy;
        logic             dBusy;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             use1;
        logic             use2;
        logic             exLoad;
        logic [REG_W-1:0] exRd;
        logic             exRedir;
        logic [63:0]      exTarget;
    } stim_t;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  flush;
        logic        pcEn;
        logic        pcRedir;
        logic [63:0] target;
        logic [31:0] stallCnt;
        logic [31:0] flushCnt;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              iBusy, dBusy;
    logic [REG_W-1:0]  idRs1, idRs2, exRd;
    logic              useRs1, useRs2, exIsLoad, exRedirect;
    logic [ADDR_W-1:0] exTarget;
    logic [3:0]        stageEn, stageFlush;
    logic              pcEn, pcRedirect;
    logic [ADDR_W-1:0] pcTarget;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       stallCycles, flushCount;
`endif

    int checks = 0;
    int errors = 0;
    exp_t expQ[$];

    // Reference model state: the redirect waiting on a fetch, and the last
    // target latched for it (which remains visible on pc_target afterwards).
    bit          havePending;
    logic [63:0] savedTarget;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;

    pipe_ctrl #(
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .CNT_W  (32)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_busy       (iBusy),
        .d_busy       (dBusy),
        .id_rs1       (idRs1),
        .id_rs2       (idRs2),
        .id_use_rs1   (useRs1),
        .id_use_rs2   (useRs2),
        .ex_is_load   (exIsLoad),
        .ex_rd        (exRd),
        .ex_redirect  (exRedirect),
        .ex_target    (exTarget),
        .stage_en     (stageEn),
        .stage_flush  (stageFlush),
        .pc_en        (pcEn),
        .pc_redirect  (pcRedirect),
        .pc_target    (pcTarget)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles (stallCycles),
        .flush_count  (flushCount)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison; prints a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: computes the response for one cycle and advances the
    // model's notion of pending redirect and counters.
    task automatic modelStep(input stim_t s, output exp_t e);
        bit lu;
        if (s.rst || s.pulse) begin
            havePending = 0;
            savedTarget = '0;
            stallCnt    = '0;
            flushCnt    = '0;
        end
        e.stallCnt = stallCnt;
        e.flushCnt = flushCnt;
        e.en       = 4'b1111;
        e.flush    = 4'b0000;
        e.pcEn     = 1'b0;
        e.pcRedir  = 1'b0;
        e.target   = savedTarget;
        if (s.rst) begin
            e.flush  = 4'b1111;
            e.target = '0;
            return;
        end
        lu = s.exLoad && (s.exRd != 0) &&
             ((s.use1 && s.rs1 == s.exRd) || (s.use2 && s.rs2 == s.exRd));
        if (s.dBusy) begin
            e.en = 4'b0000;
        end else if (!havePending && s.exRedir) begin
            e.flush   = 4'b0011;
            e.pcRedir = 1'b1;
            e.target  = s.exTarget;
            flushCnt  = flushCnt + 1;
            if (s.iBusy) begin
                havePending = 1;
                savedTarget = s.exTarget;
            end else begin
                e.pcEn = 1'b1;
            end
        end else if (havePending) begin
            e.flush   = 4'b0001;
            e.pcRedir = 1'b1;
            e.pcEn    = !s.iBusy;
            if (!s.iBusy) havePending = 0;
        end else if (lu) begin
            e.en    = 4'b1110;
            e.flush = 4'b0010;
        end else if (s.iBusy) begin
            e.flush = 4'b0001;
        end else begin
            e.pcEn = 1'b1;
        end
        if (!e.pcEn) stallCnt = stallCnt + 1;
    endtask

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected response. A pulse is an async reset wholly between edges.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        iBusy      = s.iBusy;
        dBusy      = s.dBusy;
        idRs1      = s.rs1;
        idRs2      = s.rs2;
        useRs1     = s.use1;
        useRs2     = s.use2;
        exIsLoad   = s.exLoad;
        exRd       = s.exRd;
        exRedirect = s.exRedir;
        exTarget   = s.exTarget;
        if (s.pulse) begin
            reset = 1'b1;
            #1;
            reset = 1'b0;
            #1;
        end else begin
            reset = s.rst;
        end
        modelStep(s, e);
        expQ.push_back(e);
    endtask

    function automatic stim_t idleStim();
        stim_t s;
        s.rst = 0; s.pulse = 0; s.iBusy = 0; s.dBusy = 0;
        s.rs1 = 0; s.rs2 = 0; s.use1 = 0; s.use2 = 0;
        s.exLoad = 0; s.exRd = 0; s.exRedir = 0; s.exTarget = '0;
        return s;
    endfunction

    // Monitor: outputs are combinational, so every cycle presents a result;
    // compare it mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("stage_en",    64'(stageEn),    64'(e.en));
            checkOutput("stage_flush", 64'(stageFlush), 64'(e.flush));
            checkOutput("pc_en",       64'(pcEn),       64'(e.pcEn));
            checkOutput("pc_redirect", 64'(pcRedirect), 64'(e.pcRedir));
            checkOutput("pc_target",   pcTarget,        e.target);
`ifdef PIPE_CTRL_PERF_EN
            checkOutput("stall_cycles", 64'(stallCycles), 64'(e.stallCnt));
            checkOutput("flush_count",  64'(flushCount),  64'(e.flushCnt));
`endif
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1;
        iBusy = 0; dBusy = 0; idRs1 = 0; idRs2 = 0; useRs1 = 0; useRs2 = 0;
        exIsLoad = 0; exRd = 0; exRedirect = 0; exTarget = '0;
        havePending = 0; savedTarget = '0; stallCnt = '0; flushCnt = '0;

        // Reset values.
        s = idleStim(); s.rst = 1;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idleStim());

        // Load-use on rs2, then the same with x0 as destination.
        s = idleStim(); s.exLoad = 1; s.exRd = 5; s.use2 = 1; s.rs2 = 5;
        applyStimulus(s);
        s.exRd = 0; s.rs2 = 0;
        applyStimulus(s);

        // Redirect with fetch idle.
        s = idleStim(); s.exRedir = 1; s.exTarget = 64'h8000_0040;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Redirect behind a 3-cycle outstanding fetch.
        s = idleStim(); s.exRedir = 1; s.exTarget = 64'h8000_0040; s.iBusy = 1;
        applyStimulus(s);
        s = idleStim(); s.iBusy = 1;
        applyStimulus(s);
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());

        // Data stall blocks a redirect until it clears.
        s = idleStim(); s.exRedir = 1; s.exTarget = 64'h1234_5678_9abc_def0; s.dBusy = 1;
        applyStimulus(s);
        applyStimulus(s);
        s.dBusy = 0;
        applyStimulus(s);

        // Load-use and fetch stall together: load-use wins.
        s = idleStim(); s.exLoad = 1; s.exRd = 7; s.use1 = 1; s.rs1 = 7; s.iBusy = 1;
        applyStimulus(s);

        // Async reset pulse between edges while a redirect is pending.
        s = idleStim(); s.exRedir = 1; s.exTarget = 64'hdead_beef_0000_0100; s.iBusy = 1;
        applyStimulus(s);
        s = idleStim(); s.iBusy = 1;
        applyStimulus(s);
        s = idleStim(); s.pulse = 1;
        applyStimulus(s);
        applyStimulus(idleStim());

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            s = idleStim();
            s.rst      = ($urandom_range(0, 199) == 0);
            s.iBusy    = ($urandom_range(0, 9) < 3);
            s.dBusy    = ($urandom_range(0, 9) < 2);
            s.rs1      = REG_W'($urandom_range(0, 3));
            s.rs2      = REG_W'($urandom_range(0, 3));
            s.use1     = 1'($urandom_range(0, 1));
            s.use2     = 1'($urandom_range(0, 1));
            s.exLoad   = ($urandom_range(0, 9) < 4);
            s.exRd     = REG_W'($urandom_range(0, 3));
            s.exRedir  = ($urandom_range(0, 99) < 15);
            s.exTarget = {$urandom, $urandom};
            applyStimulus(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit that drives the `en` (advance; low = hold) and `flush_en` (load bubble) inputs of the four inter-stage pipeline registers, plus the PC enable and PC redirect.
- Arbitrates data-memory stalls, instruction-memory stalls, load-use hazards and EX-stage branch/jump redirects.
- Holds a pending redirect across an outstanding instruction fetch, so the stale returning instruction is squashed.
- Sits beside the datapath in the pipeline top, consuming hazard information from ID/EX and bus busy flags.

## Interface
Parameters:
- `ADDR_W`, 64, PC/redirect target width
- `REG_W`, 5, register index width
- `CNT_W`, 32, performance counter width (only with `PIPE_CTRL_PERF_EN`)

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_busy` in 1: instruction fetch outstanding.
- `d_busy` in 1: data access outstanding in MEM.
- `id_rs1`, `id_rs2` in REG_W: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: the sources above are actually read.
- `ex_is_load` in 1: the instruction in EX is a load.
- `ex_rd` in REG_W: destination of the EX instruction.
- `ex_redirect` in 1: EX resolved a taken branch/jump or mispredict.
- `ex_target` in ADDR_W: redirect target.
- `stage_en` out 4: per-register `en`; index 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB.
- `stage_flush` out 4: per-register `flush_en`.
- `pc_en` out 1: PC register may update.
- `pc_redirect` out 1: PC next = `pc_target`.
- `pc_target` out ADDR_W: redirect target.
- `stall_cycles`, `flush_count` out CNT_W: only with `PIPE_CTRL_PERF_EN`.

## Operation
- **States:** `IDLE`, `REDIR_PEND`. A registered target `tgt_q` is kept.
- **Load-use hazard** (`lu`): `ex_is_load && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))`.
- **Priority,** evaluated combinationally each cycle, highest first:
  1. `d_busy`: `stage_en` = 0000, `stage_flush` = 0000, `pc_en` = 0. This is a full freeze; a redirect is not accepted this cycle, and EX holds so `ex_redirect` re-presents.
  2. `ex_redirect` in `IDLE`:
     - `stage_flush[1:0]` = 11, `stage_en` = 1111, `pc_redirect` = 1, `pc_target` = `ex_target`.
     - If `i_busy` = 0: `pc_en` = 1 and the state stays `IDLE`.
     - If `i_busy` = 1: `pc_en` = 0, `tgt_q` <= `ex_target`, next state `REDIR_PEND`.
     - The redirect overrides `lu`.
  3. `REDIR_PEND`:
     - `stage_flush[0]` = 1, `stage_en` = 1111, `pc_redirect` = 1, `pc_target` = `tgt_q`, `pc_en` = !`i_busy`.
     - When `i_busy` = 0: next state `IDLE`. The stale fetch is discarded by `stage_flush[0]`.
     - A new `ex_redirect` here is impossible (ID/EX was flushed) and is ignored.
  4. `lu`: `stage_en` = 1110 (IF/ID holds), `stage_flush[1]` = 1, `pc_en` = 0.
  5. `i_busy`: `stage_en` = 1111, `stage_flush[0]` = 1 (bubble into ID), `pc_en` = 0.
  6. Otherwise: `stage_en` = 1111, `stage_flush` = 0000, `pc_en` = 1, `pc_redirect` = 0.
- **Defaults:** `pc_target` = `tgt_q`; any field not set above is 0 (flush) or 1 (en).
- **`reset` asserted:**
  - State → `IDLE`, `tgt_q` → 0, counters → 0.
  - Outputs forced to `stage_en` = 1111, `stage_flush` = 1111, `pc_en` = 0, `pc_redirect` = 0, `pc_target` = 0.
  - Reset mid-`REDIR_PEND` drops the pending redirect.

## Timing
- Control outputs are combinational from inputs and state; there is zero added latency.
- The redirect PC update lands on the edge where `pc_en && pc_redirect`. This is the same edge when the fetch is idle, or the edge after `i_busy` falls.
- Load-use costs exactly one bubble.
- Simultaneous `lu` and `i_busy` resolve by `lu` (IF/ID holds, not flushed). The fetched instruction stays valid in IF because `pc_en` = 0.
- A redirect costs 2 bubbles, plus N cycles while `i_busy` stays high.

## Configuration
- **`PIPE_CTRL_PERF_EN` defined:**
  - `stall_cycles` increments each cycle in which `pc_en` = 0 and `reset` = 0.
  - `flush_count` increments once per accepted redirect (the `IDLE` cycle with `ex_redirect` and `!d_busy`).
  - Both counters wrap modulo 2^CNT_W.
- **Undefined:** the counter ports and logic are absent; behaviour is otherwise identical.

## Structure
- **`pipes` package:**
  - Stage index constants `STG_IFID=0`, `STG_IDEX=1`, `STG_EXMEM=2`, `STG_MEMWB=3`.
  - `typedef enum logic {IDLE, REDIR_PEND} pctrl_state_t`.
  - `typedef struct {logic [3:0] en; logic [3:0] flush;} stage_ctrl_t`.
- **Sub-module `hazard_detect`:** the combinational load-use comparator producing `lu`.
- **`pipe_ctrl`:** the FSM, priority mux and counters.

## Test plan
1. `ex_is_load`=1, `ex_rd`=5, `id_use_rs2`=1, `id_rs2`=5 → `stage_en`=1110, `stage_flush`=0010, `pc_en`=0. The same case with `ex_rd`=0 → no stall.
2. `ex_redirect`=1, `ex_target`=0x8000_0040, `i_busy`=0 → `stage_flush`=0011, `pc_redirect`=1, `pc_en`=1, `pc_target`=0x8000_0040.
3. Redirect with `i_busy`=1 for 3 cycles → `REDIR_PEND`, `pc_en`=0 for 3 cycles, then `pc_en`=1 with `pc_target`=0x8000_0040. `stage_flush[0]`=1 throughout; the state is `IDLE` the next cycle.
4. `d_busy`=1 together with `ex_redirect`=1 → `stage_en`=0000 and no redirect. Redirect accepted on the first cycle `d_busy`=0.
5. Assert `reset` asynchronously mid-`REDIR_PEND` → outputs go to reset values immediately, with no redirect after release.
6. With `PIPE_CTRL_PERF_EN`: one load-use, one idle-fetch redirect, and 2 `i_busy` cycles → `stall_cycles`=3, `flush_count`=1.
